// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: operation codes,
// FSM state encoding, iteration mode and small op-decoding helpers.
package mul_div_unit_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  typedef enum logic {
    MD_MODE_MUL = 1'b0,
    MD_MODE_DIV = 1'b1
  } md_mode_e;

  // Divide-family ops all have bit 2 set.
  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // Ops whose result comes from the upper accumulator half (product high / remainder).
  function automatic logic md_high_half(input logic [2:0] op);
    return (op != MD_MUL) && (op != MD_DIV) && (op != MD_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_step.sv
// One iteration of the iterative multiplier/divider, purely combinational.
// MUL mode: shift-add, accumulator = {partial product high, multiplier bits},
//   shifts right by one with the adder carry entering at the top.
// DIV mode: restoring shift-subtract, accumulator = {partial remainder, dividend
//   bits}, shifts left by one; the quotient bit is returned separately and the
//   LSB of acc_o is left 0 for the caller to fill.
module mul_div_step
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  input  md_mode_e          mode_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic              q_bit_o
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;
  logic [XLEN:0] sum;

  // Single shift-add or shift-subtract step selected by mode.
  always_comb begin
    rem_sh  = '0;
    diff    = '0;
    sum     = '0;
    acc_o   = '0;
    q_bit_o = 1'b0;
    if (mode_i == MD_MODE_DIV) begin
      rem_sh = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
      diff   = rem_sh - {1'b0, opnd_i};
      if (!diff[XLEN]) begin
        q_bit_o = 1'b1;
        acc_o   = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end else begin
        acc_o   = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end
    end else begin
      sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
      acc_o = {sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide execute unit (one op in flight).
// Optional macro MUL_DIV_EARLY_OUT_EN: divide-by-zero, signed divide overflow
// and multiply-by-zero skip the iterations and finish one cycle after start.
//
// Handshake: start is only looked at while busy=0 (IDLE); the op is taken on
// the edge where start=1 and flush=0. busy stays high through CALC and DONE, so
// upstream must hold the instruction until busy drops. done is a one-cycle
// strobe; result/dst_num_out are meaningful only while done=1. flush kills the
// op at the next edge and masks done in the current cycle.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [4:0]      dst_num_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      dst_num_out,
  output logic [1:0]      state_dbg
);

  if (XLEN != 32) begin : g_xlen_check
    $error("mul_div_unit: only XLEN=32 is supported");
  end
  if (CNT_W != $clog2(XLEN)) begin : g_cnt_check
    $error("mul_div_unit: CNT_W must be log2(XLEN)");
  end

  md_state_e         state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        dst_q, dst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              s1_signed, s2_signed, neg1, neg2;
  logic [XLEN-1:0]   mag1, mag2;
  logic [2*XLEN-1:0] step_acc, acc_next, prod;
  logic              step_q;
  logic [XLEN-1:0]   half, fin_res;
  md_mode_e          mode;

  // Operand sign decoding and magnitudes for the incoming instruction.
  always_comb begin
    s1_signed = (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    s2_signed = (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    neg1      = s1_signed && src1[XLEN-1];
    neg2      = s2_signed && src2[XLEN-1];
    mag1      = neg1 ? -src1 : src1;
    mag2      = neg2 ? -src2 : src2;
  end

  assign mode = md_is_div(op_q) ? MD_MODE_DIV : MD_MODE_MUL;

  mul_div_step #(.XLEN(XLEN)) u_step (
    .acc_i   (acc_q),
    .opnd_i  (opnd_q),
    .mode_i  (mode),
    .acc_o   (step_acc),
    .q_bit_o (step_q)
  );

  // Last-iteration result: full 64-bit negate for products, per-half for quotient/remainder.
  always_comb begin
    acc_next = step_acc | {{(2*XLEN-1){1'b0}}, step_q};
    prod     = neg_q ? -acc_next : acc_next;
    half     = md_high_half(op_q) ? acc_next[2*XLEN-1:XLEN] : acc_next[XLEN-1:0];
    if (md_is_div(op_q)) begin
      fin_res = neg_q ? -half : half;
    end else begin
      fin_res = md_high_half(op_q) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end
  end

`ifdef MUL_DIV_EARLY_OUT_EN
  logic            early_hit;
  logic [XLEN-1:0] early_res;

  // Trivial cases whose answer is known without iterating.
  always_comb begin
    early_hit = 1'b0;
    early_res = '0;
    if (md_is_div(op)) begin
      if (src2 == '0) begin
        early_hit = 1'b1;
        early_res = op[1] ? src1 : '1;
      end else if (!op[0] && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1)) begin
        early_hit = 1'b1;
        early_res = op[1] ? '0 : src1;
      end
    end else if ((src1 == '0) || (src2 == '0)) begin
      early_hit = 1'b1;
    end
  end
`endif

  // Next-state and datapath update for the IDLE/CALC/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dst_d    = dst_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      MD_IDLE: begin
        if (start && !flush) begin
          state_d = MD_CALC;
          op_d    = op;
          dst_d   = dst_num_in;
          cnt_d   = '0;
          acc_d   = md_is_div(op) ? {{XLEN{1'b0}}, mag1} : {{XLEN{1'b0}}, mag2};
          opnd_d  = md_is_div(op) ? mag2 : mag1;
          case (md_op_e'(op))
            MD_MULH:   neg_d = neg1 ^ neg2;
            MD_MULHSU: neg_d = neg1;
            MD_DIV:    neg_d = (neg1 ^ neg2) && (src2 != '0);
            MD_REM:    neg_d = neg1;
            default:   neg_d = 1'b0;
          endcase
`ifdef MUL_DIV_EARLY_OUT_EN
          if (early_hit) begin
            state_d  = MD_DONE;
            result_d = early_res;
          end
`endif
        end
      end
      MD_CALC: begin
        if (flush) begin
          state_d = MD_IDLE;
        end else begin
          acc_d = acc_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) begin
            state_d  = MD_DONE;
            result_d = fin_res;
          end
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= MD_IDLE;
      op_q     <= '0;
      dst_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign busy        = (state_q != MD_IDLE);
  assign done        = ((state_q == MD_DONE) && !flush) ? ENABLE : DISABLE;
  assign result      = result_q;
  assign dst_num_out = dst_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: reference model from the RV32M arithmetic rules,
// expected-result queue and a per-cycle compare process.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src1, src2;
  logic [4:0]  dst_num_in;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  dst_num_out;
  logic [1:0]  state_dbg;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  dst;
    int          start_c;
    int          done_c;
    int          kill_c;
  } exp_t;

  exp_t exp_q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  mul_div_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .src1        (src1),
    .src2        (src2),
    .dst_num_in  (dst_num_in),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .dst_num_out (dst_num_out),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / cycle count ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] p;
    int          ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = a;
    ib = b;
    case (o)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit tb_early(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2]) return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (a == 0) || (b == 0);
  endfunction

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    logic busy_e, done_e;
    if (exp_q.size() > 0 && cyc > exp_q[0].kill_c) void'(exp_q.pop_front());
    busy_e = (exp_q.size() > 0) && (cyc >= exp_q[0].start_c) && (cyc <= exp_q[0].kill_c);
    done_e = (exp_q.size() > 0) && (cyc == exp_q[0].done_c) && (cyc < exp_q[0].kill_c);
    check("busy", {31'b0, busy}, {31'b0, busy_e});
    check("done", {31'b0, done}, {31'b0, done_e});
    if (done_e) begin
      check("result", result, exp_q[0].res);
      check("dst_num_out", {27'b0, dst_num_out}, {27'b0, exp_q[0].dst});
    end
    if (exp_q.size() > 0 && cyc >= exp_q[0].done_c) void'(exp_q.pop_front());
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() != 0) begin
      check("idle_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  // ev: 0 none, 1 second start, 2 flush, 3 async reset; ev_at = cycles after capture edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input logic [31:0] exp_r, input int ev, input int ev_at);
    exp_t e;
    int   c0, lat;
    wait_idle();
    start = 1'b1; op = o; src1 = a; src2 = b; dst_num_in = d;
    c0  = cyc + 1;
    lat = 32;
`ifdef MUL_DIV_EARLY_OUT_EN
    if (tb_early(o, a, b)) lat = 0;
`endif
    e.res = exp_r; e.dst = d; e.start_c = c0; e.done_c = c0 + lat; e.kill_c = 1000000000;
    exp_q.push_back(e);
    @(posedge clk); #1;
    start = 1'b0; op = 3'($urandom_range(0, 7)); src1 = $urandom; src2 = $urandom;
    dst_num_in = 5'($urandom_range(0, 31));
    if (ev != 0) begin
      while (cyc < c0 + ev_at) begin
        @(posedge clk); #1;
      end
      if (ev == 1) begin
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end else if (ev == 2) begin
        flush = 1'b1;
        e = exp_q[0]; e.kill_c = cyc; exp_q[0] = e;
        @(posedge clk); #1;
        flush = 1'b0;
      end else begin
        rst = 1'b0;
        e = exp_q[0]; e.kill_c = cyc - 1; exp_q[0] = e;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_dst", {27'b0, dst_num_out}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
      end
    end
  endtask

  // Directed op: pin the model to a hand-computed value, then run it against the DUT.
  task automatic dir_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [31:0] lit);
    check("model_pin", ref_result(o, a, b), lit);
    run_op(o, a, b, 5'($urandom_range(0, 31)), lit, 0, 0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; src1 = '0; src2 = '0; dst_num_in = '0;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_dst", {27'b0, dst_num_out}, 32'd0);
    check("reset_state", {30'b0, state_dbg}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    dir_op(MD_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    dir_op(MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    dir_op(MD_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    dir_op(MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    dir_op(MD_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    dir_op(MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    dir_op(MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    dir_op(MD_DIVU,   32'd7,         32'd2,         32'd3);
    dir_op(MD_REMU,   32'd7,         32'd2,         32'd1);
    dir_op(MD_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF);
    dir_op(MD_REMU,   32'd5,         32'd0,         32'd5);
    dir_op(MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    dir_op(MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
    dir_op(MD_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF);
    dir_op(MD_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9);
    dir_op(MD_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF);
    dir_op(MD_MULHU,  32'd0,         32'd12345,     32'h0);

    // Mid-operation events on operations that always iterate.
    run_op(MD_MULH, 32'h1234_5678, 32'h8765_4321, 5'd9,
           ref_result(MD_MULH, 32'h1234_5678, 32'h8765_4321), 1, 10);
    run_op(MD_DIV, 32'd1000, 32'd7, 5'd3, 32'd142, 2, 15);
    run_op(MD_REMU, 32'd1000, 32'd7, 5'd4, 32'd6, 2, 32);
    run_op(MD_DIVU, 32'd1000, 32'd7, 5'd5, 32'd142, 3, 20);
    dir_op(MD_MUL, 32'd6, 32'd7, 32'd42);

    // start together with flush in IDLE: nothing may be captured.
    wait_idle();
    start = 1'b1; flush = 1'b1; op = MD_DIV; src1 = 32'd9; src2 = 32'd3; dst_num_in = 5'd7;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    // Randomized operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      run_op(ro, ra, rb, 5'($urandom_range(0, 31)), ref_result(ro, ra, rb), 0, 0);
    end

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
